// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM encoding
// and the vector address helper.
package irq_pkg;

    localparam logic [1:0] IRQ_MASK   = 2'd0;
    localparam logic [1:0] IRQ_PEND   = 2'd1;
    localparam logic [1:0] IRQ_ACTIVE = 2'd2;
    localparam logic [1:0] IRQ_EOI    = 2'd3;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

    // Handler address for a source; the 32-bit result wraps naturally.
    function automatic logic [31:0] irq_vector(input logic [31:0] base,
                                               input logic [31:0] stride,
                                               input logic [4:0]  id);
        return base + ({27'd0, id} * stride);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] req,
    output logic             any,
    output logic [4:0]       id
);

    // Scan from the top down so the lowest index overwrites last.
    always_comb begin
        any = 1'b0;
        id  = 5'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            any = any | req[i];
            id  = req[i] ? 5'(i) : id;
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller: latches pending requests, presents the
// highest-priority enabled one to the CPU and holds it through ack and EOI.
module irq_controller
    import irq_pkg::*;
#(
    parameter int          N_SRC      = 8,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0018,
    parameter int          VEC_STRIDE = 4
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic [N_SRC-1:0] src_irq,
    input  logic             irq_ack,
    input  logic             reg_we,
    input  logic [1:0]       reg_addr,
    input  logic [31:0]      reg_wdata,
    output logic [31:0]      reg_rdata,
    output logic             EX_irq,
    output logic [31:0]      INT_Vector,
    output logic [4:0]       active_id
);

    logic [N_SRC-1:0] src_prev_r;
    logic [N_SRC-1:0] pending_r;
    logic [N_SRC-1:0] mask_r;
    irq_state_e       state_r;
    logic             ex_irq_r;
    logic [31:0]      int_vector_r;
    logic [4:0]       active_id_r;

    logic [N_SRC-1:0] rise_s;
    logic [N_SRC-1:0] active_oh_s;
    logic [N_SRC-1:0] w1c_s;
    logic [N_SRC-1:0] ack_clr_s;
    logic [N_SRC-1:0] pending_nxt_s;
    logic [N_SRC-1:0] eligible_s;
    logic             win_any_s;
    logic [4:0]       win_id_s;
    logic             ack_take_s;
    logic             act_pending_s;
    logic             act_enabled_s;
    logic             mask_we_s;
    logic             eoi_s;
    logic             valid_s;
    logic [31:0]      rdata_s;
    logic             unused_wdata_s;

    // One-hot decode of the presented id, avoiding a variable-width bit select.
    always_comb begin
        active_oh_s = {N_SRC{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            active_oh_s[i] = (active_id_r == 5'(i));
        end
    end

    assign rise_s        = src_irq & ~src_prev_r;
    assign ack_take_s    = (state_r == IRQ_REQ) && irq_ack;
    assign mask_we_s     = reg_we && (reg_addr == IRQ_MASK);
    assign eoi_s         = reg_we && (reg_addr == IRQ_EOI);
    assign w1c_s         = (reg_we && (reg_addr == IRQ_PEND)) ? reg_wdata[N_SRC-1:0] : {N_SRC{1'b0}};
    assign ack_clr_s     = ack_take_s ? active_oh_s : {N_SRC{1'b0}};
    // A rise in the same cycle as a clear keeps the bit pending.
    assign pending_nxt_s = (pending_r & ~(w1c_s | ack_clr_s)) | rise_s;
    assign eligible_s    = pending_r & mask_r;
    assign act_pending_s = |(pending_r & active_oh_s);
    assign act_enabled_s = |(mask_r & active_oh_s);
    assign valid_s       = (state_r == IRQ_REQ) || (state_r == IRQ_SERVICE);
    assign unused_wdata_s = ^reg_wdata;

    irq_prio_enc #(.N_SRC(N_SRC)) u_prio (
        .req (eligible_s),
        .any (win_any_s),
        .id  (win_id_s)
    );

    // Edge history, pending latch and mask register.
    always_ff @(posedge clk) begin
        if (Rst) begin
            src_prev_r <= {N_SRC{1'b0}};
            pending_r  <= {N_SRC{1'b0}};
            mask_r     <= {N_SRC{1'b0}};
        end else begin
            src_prev_r <= src_irq;
            pending_r  <= pending_nxt_s;
            if (mask_we_s) begin
                mask_r <= reg_wdata[N_SRC-1:0];
            end
        end
    end

    // Request/service FSM with registered CPU-facing outputs.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_r      <= IRQ_IDLE;
            ex_irq_r     <= 1'b0;
            int_vector_r <= 32'd0;
            active_id_r  <= 5'd0;
        end else begin
            case (state_r)
                IRQ_IDLE: begin
                    if (win_any_s) begin
                        state_r      <= IRQ_REQ;
                        ex_irq_r     <= 1'b1;
                        active_id_r  <= win_id_s;
                        int_vector_r <= irq_vector(VEC_BASE, 32'(VEC_STRIDE), win_id_s);
                    end
                end
                IRQ_REQ: begin
                    if (irq_ack) begin
                        state_r  <= IRQ_SERVICE;
                        ex_irq_r <= 1'b0;
                    end else if (!act_pending_s || !act_enabled_s) begin
                        state_r  <= IRQ_IDLE;
                        ex_irq_r <= 1'b0;
                    end
                end
                IRQ_SERVICE: begin
                    ex_irq_r <= 1'b0;
                    if (eoi_s) begin
                        state_r <= IRQ_IDLE;
                    end
                end
                default: begin
                    state_r  <= IRQ_IDLE;
                    ex_irq_r <= 1'b0;
                end
            endcase
        end
    end

    // Register read mux; reads have no side effects.
    always_comb begin
        rdata_s = 32'd0;
        case (reg_addr)
            IRQ_MASK:   rdata_s[N_SRC-1:0] = mask_r;
            IRQ_PEND:   rdata_s[N_SRC-1:0] = pending_r;
            IRQ_ACTIVE: rdata_s = {valid_s, 26'd0, active_id_r};
            IRQ_EOI:    rdata_s = 32'd0;
            default:    rdata_s = 32'd0;
        endcase
    end

    assign reg_rdata  = rdata_s;
    assign EX_irq     = ex_irq_r;
    assign INT_Vector = int_vector_r;
    assign active_id  = active_id_r;

endmodule

// File: tb/tb_irq_controller.sv
// Table-driven scoreboard bench for irq_controller with the default parameters.
module tb_irq_controller;
    import irq_pkg::*;

    typedef struct {
        logic        rst;
        logic [7:0]  src;
        logic        ack;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic        chk;
        logic        ex;
        logic [31:0] vec;
        logic [4:0]  id;
        logic [31:0] rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic [7:0]  src_irq = 8'd0;
    logic        irq_ack = 1'b0;
    logic        reg_we = 1'b0;
    logic [1:0]  reg_addr = 2'd0;
    logic [31:0] reg_wdata = 32'd0;
    logic [31:0] reg_rdata;
    logic        EX_irq;
    logic [31:0] INT_Vector;
    logic [4:0]  active_id;

    int n_run  = 0;
    int n_fail = 0;
    vec_t tbl[$];
    vec_t sb[$];

    irq_controller dut (
        .clk        (clk),
        .Rst        (Rst),
        .src_irq    (src_irq),
        .irq_ack    (irq_ack),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .EX_irq     (EX_irq),
        .INT_Vector (INT_Vector),
        .active_id  (active_id)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic [7:0] src, input logic ack,
                                input logic we, input logic [1:0] addr, input logic [31:0] wd,
                                input logic chk, input logic ex, input logic [31:0] vec,
                                input logic [4:0] id, input logic [31:0] rd);
        vec_t v;
        v.rst = rst; v.src = src; v.ack = ack; v.we = we; v.addr = addr; v.wd = wd;
        v.chk = chk; v.ex = ex; v.vec = vec; v.id = id; v.rd = rd;
        return v;
    endfunction

    task automatic cmp(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: actual %h required %h", name, row, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int row);
        vec_t e;
        @(negedge clk);
        Rst = v.rst; src_irq = v.src; irq_ack = v.ack;
        reg_we = v.we; reg_addr = v.addr; reg_wdata = v.wd;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL scoreboard row %0d: actual empty required entry", row);
        end else begin
            e = sb.pop_front();
            if (e.chk) begin
                cmp("ex_irq", row, {31'd0, EX_irq}, {31'd0, e.ex});
                cmp("int_vector", row, INT_Vector, e.vec);
                cmp("active_id", row, {27'd0, active_id}, {27'd0, e.id});
            end
            cmp("reg_rdata", row, reg_rdata, e.rd);
        end
    endtask

    initial begin
        // Reset state
        tbl.push_back(mk(1, 8'h00, 0, 0, IRQ_MASK,   32'h0,  1, 0, 32'h0,  5'd0, 32'h0));
        tbl.push_back(mk(1, 8'h00, 0, 0, IRQ_PEND,   32'h0,  1, 0, 32'h0,  5'd0, 32'h0));
        tbl.push_back(mk(1, 8'h00, 0, 0, IRQ_ACTIVE, 32'h0,  1, 0, 32'h0,  5'd0, 32'h0));
        // Single enabled source 2
        tbl.push_back(mk(0, 8'h00, 0, 1, IRQ_MASK,   32'h04, 1, 0, 32'h0,  5'd0, 32'h04));
        tbl.push_back(mk(0, 8'h04, 0, 0, IRQ_PEND,   32'h0,  1, 0, 32'h0,  5'd0, 32'h04));
        tbl.push_back(mk(0, 8'h00, 0, 0, IRQ_PEND,   32'h0,  1, 1, 32'h20, 5'd2, 32'h04));
        tbl.push_back(mk(0, 8'h00, 1, 0, IRQ_ACTIVE, 32'h0,  1, 0, 32'h20, 5'd2, 32'h8000_0002));
        tbl.push_back(mk(0, 8'h00, 0, 0, IRQ_PEND,   32'h0,  1, 0, 32'h20, 5'd2, 32'h0));
        tbl.push_back(mk(0, 8'h00, 0, 1, IRQ_EOI,    32'h0,  1, 0, 32'h20, 5'd2, 32'h0));
        tbl.push_back(mk(0, 8'h00, 0, 0, IRQ_ACTIVE, 32'h0,  1, 0, 32'h20, 5'd2, 32'h2));
        // Sources 1 and 5 together: priority order
        tbl.push_back(mk(0, 8'h00, 0, 1, IRQ_MASK,   32'h22, 1, 0, 32'h20, 5'd2, 32'h22));
        tbl.push_back(mk(0, 8'h22, 0, 0, IRQ_PEND,   32'h0,  1, 0, 32'h20, 5'd2, 32'h22));
        tbl.push_back(mk(0, 8'h22, 0, 0, IRQ_PEND,   32'h0,  1, 1, 32'h1C, 5'd1, 32'h22));
        tbl.push_back(mk(0, 8'h22, 1, 0, IRQ_PEND,   32'h0,  1, 0, 32'h1C, 5'd1, 32'h20));
        tbl.push_back(mk(0, 8'h00, 0, 1, IRQ_EOI,    32'h0,  1, 0, 32'h1C, 5'd1, 32'h0));
        tbl.push_back(mk(0, 8'h00, 0, 0, IRQ_PEND,   32'h0,  1, 1, 32'h2C, 5'd5, 32'h20));
        tbl.push_back(mk(0, 8'h00, 1, 0, IRQ_PEND,   32'h0,  1, 0, 32'h2C, 5'd5, 32'h0));
        tbl.push_back(mk(0, 8'h00, 0, 1, IRQ_EOI,    32'h0,  1, 0, 32'h2C, 5'd5, 32'h0));
        // Masked source 3, then enabled
        tbl.push_back(mk(0, 8'h08, 0, 0, IRQ_PEND,   32'h0,  1, 0, 32'h2C, 5'd5, 32'h08));
        tbl.push_back(mk(0, 8'h00, 0, 0, IRQ_PEND,   32'h0,  1, 0, 32'h2C, 5'd5, 32'h08));
        tbl.push_back(mk(0, 8'h00, 0, 1, IRQ_MASK,   32'h08, 1, 0, 32'h2C, 5'd5, 32'h08));
        tbl.push_back(mk(0, 8'h00, 0, 0, IRQ_PEND,   32'h0,  1, 1, 32'h24, 5'd3, 32'h08));
        tbl.push_back(mk(0, 8'h00, 1, 0, IRQ_PEND,   32'h0,  1, 0, 32'h24, 5'd3, 32'h0));
        tbl.push_back(mk(0, 8'h00, 0, 1, IRQ_EOI,    32'h0,  1, 0, 32'h24, 5'd3, 32'h0));
        // Software clear of pending withdraws the request
        tbl.push_back(mk(0, 8'h04, 0, 1, IRQ_MASK,   32'h04, 1, 0, 32'h24, 5'd3, 32'h04));
        tbl.push_back(mk(0, 8'h04, 0, 0, IRQ_PEND,   32'h0,  1, 1, 32'h20, 5'd2, 32'h04));
        tbl.push_back(mk(0, 8'h04, 0, 1, IRQ_PEND,   32'h04, 0, 0, 32'h0,  5'd0, 32'h0));
        tbl.push_back(mk(0, 8'h04, 0, 0, IRQ_ACTIVE, 32'h0,  1, 0, 32'h20, 5'd2, 32'h2));
        tbl.push_back(mk(0, 8'h04, 0, 0, IRQ_PEND,   32'h0,  1, 0, 32'h20, 5'd2, 32'h0));
        // No nesting in SERVICE; source 0 waits for EOI
        tbl.push_back(mk(0, 8'h00, 0, 1, IRQ_MASK,   32'h05, 1, 0, 32'h20, 5'd2, 32'h05));
        tbl.push_back(mk(0, 8'h04, 0, 0, IRQ_PEND,   32'h0,  1, 0, 32'h20, 5'd2, 32'h04));
        tbl.push_back(mk(0, 8'h00, 0, 0, IRQ_PEND,   32'h0,  1, 1, 32'h20, 5'd2, 32'h04));
        tbl.push_back(mk(0, 8'h00, 1, 0, IRQ_PEND,   32'h0,  1, 0, 32'h20, 5'd2, 32'h0));
        tbl.push_back(mk(0, 8'h01, 0, 0, IRQ_PEND,   32'h0,  1, 0, 32'h20, 5'd2, 32'h01));
        tbl.push_back(mk(0, 8'h00, 0, 0, IRQ_ACTIVE, 32'h0,  1, 0, 32'h20, 5'd2, 32'h8000_0002));
        tbl.push_back(mk(0, 8'h00, 0, 1, IRQ_EOI,    32'h0,  1, 0, 32'h20, 5'd2, 32'h0));
        tbl.push_back(mk(0, 8'h00, 0, 0, IRQ_PEND,   32'h0,  1, 1, 32'h18, 5'd0, 32'h01));
        tbl.push_back(mk(0, 8'h00, 1, 0, IRQ_PEND,   32'h0,  1, 0, 32'h18, 5'd0, 32'h0));
        tbl.push_back(mk(0, 8'h00, 0, 1, IRQ_EOI,    32'h0,  1, 0, 32'h18, 5'd0, 32'h0));
        // Rise beats W1C; ack in IDLE ignored
        tbl.push_back(mk(0, 8'h00, 0, 1, IRQ_MASK,   32'h00, 1, 0, 32'h18, 5'd0, 32'h0));
        tbl.push_back(mk(0, 8'h10, 0, 1, IRQ_PEND,   32'h10, 1, 0, 32'h18, 5'd0, 32'h10));
        tbl.push_back(mk(0, 8'h00, 1, 0, IRQ_PEND,   32'h0,  1, 0, 32'h18, 5'd0, 32'h10));
        tbl.push_back(mk(0, 8'h00, 0, 1, IRQ_MASK,   32'h10, 1, 0, 32'h18, 5'd0, 32'h10));
        tbl.push_back(mk(0, 8'h00, 0, 0, IRQ_ACTIVE, 32'h0,  1, 1, 32'h28, 5'd4, 32'h8000_0004));
        // Masking the presented source withdraws it
        tbl.push_back(mk(0, 8'h00, 0, 1, IRQ_MASK,   32'h00, 0, 0, 32'h0,  5'd0, 32'h0));
        tbl.push_back(mk(0, 8'h00, 0, 0, IRQ_ACTIVE, 32'h0,  1, 0, 32'h28, 5'd4, 32'h4));
        tbl.push_back(mk(0, 8'h00, 1, 0, IRQ_PEND,   32'h0,  1, 0, 32'h28, 5'd4, 32'h10));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], i);
        end

        // Reset while in REQ, then a source held high across reset
        step(mk(0, 8'h10, 0, 1, IRQ_MASK,   32'h10, 1, 0, 32'h28, 5'd4, 32'h10), 100);
        step(mk(0, 8'h10, 0, 0, IRQ_ACTIVE, 32'h0,  1, 1, 32'h28, 5'd4, 32'h8000_0004), 101);
        step(mk(1, 8'h10, 0, 0, IRQ_ACTIVE, 32'h0,  1, 0, 32'h0,  5'd0, 32'h0), 102);
        step(mk(0, 8'h10, 0, 0, IRQ_PEND,   32'h0,  1, 0, 32'h0,  5'd0, 32'h10), 103);
        step(mk(0, 8'h10, 0, 0, IRQ_MASK,   32'h0,  1, 0, 32'h0,  5'd0, 32'h0), 104);
        step(mk(0, 8'h10, 0, 1, IRQ_PEND,   32'h10, 1, 0, 32'h0,  5'd0, 32'h0), 105);
        step(mk(0, 8'h10, 0, 0, IRQ_PEND,   32'h0,  1, 0, 32'h0,  5'd0, 32'h0), 106);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt source for the multi-cycle ARM-model CPU. It edge-detects up to `N_SRC` peripheral request lines and latches them as pending. It selects the highest-priority enabled request and drives the CPU's `EX_irq` and `INT_Vector` inputs, then waits for the CPU's acknowledge and a software end-of-interrupt. It sits between the peripherals and `CPU`, with a small register port on the CPU data bus for mask, pending and EOI control.

## Interface
Parameters:
- `N_SRC`, 8: number of request sources, 1..32.
- `VEC_BASE`, 32'h0000_0018: vector address for source 0 (ARM IRQ vector).
- `VEC_STRIDE`, 4: byte spacing between per-source vectors.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `Rst`  in  1  synchronous active-high reset.
- `src_irq`  in  N_SRC  peripheral request lines; a rising edge raises a request.
- `irq_ack`  in  1  one-cycle pulse from the CPU when it enters IRQ mode.
- `reg_we`  in  1  register write strobe.
- `reg_addr`  in  2  register select: 0 MASK, 1 PENDING, 2 ACTIVE, 3 EOI.
- `reg_wdata`  in  32  write data.
- `reg_rdata`  out  32  combinational read data for `reg_addr`.
- `EX_irq`  out  1  registered interrupt request to the CPU.
- `INT_Vector`  out  32  registered handler address, valid while `EX_irq` = 1.
- `active_id`  out  5  id of the request being presented or serviced.

## Operation
- Edge detect: `src_prev` holds `src_irq` from the previous cycle. `rise = src_irq & ~src_prev`, and each rise sets its pending bit.
- Pending bits set regardless of mask; mask only gates selection.
- MASK (addr 0): read/write, bit i enables source i; bits at or above `N_SRC` read 0.
- PENDING (addr 1): a read returns the pending bits; writing 1 to a bit clears it.
- ACTIVE (addr 2): read-only; returns {valid, 26'b0, `active_id`}, where valid = 1 in REQ or SERVICE.
- EOI (addr 3): a write with any data ends service; it has no effect outside SERVICE.
- Priority: the lowest index among `pending & mask` wins (fixed priority).
- FSM states:
  - IDLE: if `pending & mask` ≠ 0, latch the winning id into `active_id`, set `INT_Vector = VEC_BASE + id*VEC_STRIDE` (32-bit, wraps mod 2^32) and `EX_irq` = 1, then go to REQ.
  - REQ: hold `EX_irq` and `INT_Vector` stable; no re-arbitration, even if a higher-priority request arrives.
    - On `irq_ack`: clear `pending[active_id]`, set `EX_irq` = 0, go to SERVICE.
    - If `pending[active_id]` is cleared by software, or `mask[active_id]` becomes 0, without `irq_ack`: withdraw (`EX_irq` = 0) and go to IDLE. `irq_ack` takes priority over a withdrawal in the same cycle.
  - SERVICE: no nesting; new requests only accumulate as pending. An EOI write returns the FSM to IDLE.
- Simultaneous set and clear of the same pending bit (a rise plus a W1C write, or a rise plus an ack clear): set wins.
- `irq_ack` outside REQ is ignored.

## Timing
- Reset values: `EX_irq` = 0, `INT_Vector` = 0, `active_id` = 0, MASK = 0, PENDING = 0, `src_prev` = 0, FSM = IDLE.
- `Rst` mid-operation abandons any REQ or SERVICE immediately; a source held high through reset does not re-trigger until it falls and rises again, except that a source high at the first post-reset edge counts as a rise (`src_prev` = 0).
- Latency from a `src_irq` rise (sampled at edge n):
  - pending visible after edge n;
  - `EX_irq` = 1 after edge n+1, if the source is enabled and the FSM is in IDLE.
- `irq_ack` sampled at edge k: `EX_irq` = 0 and pending cleared after edge k.
- EOI write at edge k: IDLE after edge k. The next request can assert `EX_irq` after edge k+1.
- MASK and PENDING writes take effect after the write edge. Arbitration in IDLE uses the post-update values one cycle later.
- `reg_rdata` is combinational from the current register state; no read side effects.

## Structure
- Shared package `irq_pkg`:
  - register address constants `IRQ_MASK`, `IRQ_PEND`, `IRQ_ACTIVE`, `IRQ_EOI`;
  - FSM state encoding `IRQ_IDLE`, `IRQ_REQ`, `IRQ_SERVICE` (2-bit).
- One sub-module: `irq_prio_enc`, a combinational lowest-index-first encoder, `N_SRC` in → {any, id[4:0]} out.

## Test plan
- Reset, MASK = 8'h04, pulse `src_irq[2]` → PENDING = 8'h04 next cycle; `EX_irq` = 1 and `INT_Vector` = 32'h20 the cycle after.
- Pending bits 1 and 5 both enabled, FSM in IDLE → `active_id` = 1, `INT_Vector` = 32'h1C. Then `irq_ack` and EOI → `active_id` = 5, `INT_Vector` = 32'h2C.
- Masked source 3 pulsed → PENDING = 8'h08, `EX_irq` stays 0. Write MASK = 8'h08 → `EX_irq` = 1 two edges later.
- In REQ for source 2, write PENDING = 8'h04 → `EX_irq` = 0 next cycle, FSM back to IDLE, no ack required.
- In SERVICE, pulse source 0 → pending set, `EX_irq` stays 0 until EOI. After EOI, `EX_irq` = 1 with `INT_Vector` = 32'h18.
- Rise on source 4 in the same cycle as a PENDING write of 8'h10 → bit 4 remains pending. Assert `Rst` in REQ → all outputs zero after the reset edge.
